// File: rtl/pool_window_buffer.sv
// Streaming 2x2 / stride-2 window former feeding the max-pooling stage.
// Even rows land in a line buffer; each odd-row, odd-column pixel closes a window.
module pool_window_buffer #(
    parameter int WIDTH = 8,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [WIDTH-1:0]   i_pixel,
    input  logic               i_valid,
    output logic               o_ready,
    output logic [4*WIDTH-1:0] o_window,
    output logic               o_valid,
    input  logic               i_ready,
    output logic               o_frame_done
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0]      r_col;
    logic [RW-1:0]      r_row;
    logic [WIDTH-1:0]   r_hold;
    logic [WIDTH-1:0]   r_line_buf [IMG_W];
    logic [4*WIDTH-1:0] r_window;
    logic               r_valid;
    logic               r_frame_done;

    logic               w_accept;
    logic               w_consume;
    logic               w_col_last;
    logic               w_row_last;
    logic               w_emit;
    logic [CW-1:0]      w_col_prev;

    // Valid/ready: a transfer happens on any edge where valid and ready are both high.
    // A held window blocks input so the window register is never overwritten unconsumed.
    assign o_ready    = en & (~r_valid | i_ready);
    assign w_accept   = i_valid & o_ready;
    assign w_consume  = r_valid & i_ready;
    assign w_col_last = (r_col == COL_LAST);
    assign w_row_last = (r_row == ROW_LAST);
    assign w_emit     = w_accept & r_row[0] & r_col[0];
    assign w_col_prev = r_col - CW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col  <= '0;
            r_row  <= '0;
            r_hold <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
            if (r_row[0] & ~r_col[0]) begin
                r_hold <= i_pixel;
            end
        end
    end

    // Line buffer carries no reset; stale contents are always overwritten before use.
    always_ff @(posedge clk) begin
        if (w_accept & ~r_row[0]) begin
            r_line_buf[r_col] <= i_pixel;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_window     <= '0;
            r_valid      <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_accept & w_col_last & w_row_last;
            if (w_emit) begin
                r_window <= {i_pixel, r_hold, r_line_buf[r_col], r_line_buf[w_col_prev]};
                r_valid  <= 1'b1;
            end else if (w_consume) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_window     = r_window;
    assign o_valid      = r_valid;
    assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_pool_window_buffer.sv
// Bench for pool_window_buffer: a 4x4 and a 5x3 instance share one stimulus bus,
// with a frame-array reference model and an expected-window queue.
module tb_pool_window_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        i_valid;
    logic        i_ready;
    logic        sel;
    logic [7:0]  i_pixel;

    logic        rdy_a, val_a, fd_a, rdy_b, val_b, fd_b;
    logic [31:0] win_a, win_b;
    logic        o_ready, o_valid, o_frame_done;
    logic [31:0] o_window;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  img [0:7][0:7];
    int          pos = 0;
    bit          fd_exp = 0;
    bit          pend = 0;
    logic [31:0] pend_win;
    bit          hold_prev = 0;
    logic [31:0] prev_win;
    int          win_cnt = 0;
    int          fd_cnt = 0;

    typedef struct {
        logic [7:0]  pix;
        bit          v;
        logic [31:0] win;
        bit          fd;
    } vec_t;
    vec_t tbl[16];

    always #5 clk = ~clk;

    pool_window_buffer #(.WIDTH(8), .IMG_W(4), .IMG_H(4)) dut_a (
        .clk(clk), .rst(rst), .en(en), .i_pixel(i_pixel), .i_valid(i_valid & ~sel),
        .o_ready(rdy_a), .o_window(win_a), .o_valid(val_a), .i_ready(i_ready),
        .o_frame_done(fd_a)
    );

    pool_window_buffer #(.WIDTH(8), .IMG_W(5), .IMG_H(3)) dut_b (
        .clk(clk), .rst(rst), .en(en), .i_pixel(i_pixel), .i_valid(i_valid & sel),
        .o_ready(rdy_b), .o_window(win_b), .o_valid(val_b), .i_ready(i_ready),
        .o_frame_done(fd_b)
    );

    assign o_ready      = sel ? rdy_b : rdy_a;
    assign o_valid      = sel ? val_b : val_a;
    assign o_window     = sel ? win_b : win_a;
    assign o_frame_done = sel ? fd_b : fd_a;

    function automatic int cur_w();
        return sel ? 5 : 4;
    endfunction

    function automatic int cur_h();
        return sel ? 3 : 4;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: place each accepted pixel in a 2-D frame; an odd/odd position closes a window.
    task automatic model_accept(input logic [7:0] p);
        int r;
        int c;
        logic [31:0] w;
        r = pos / cur_w();
        c = pos % cur_w();
        img[r][c] = p;
        if ((r % 2 == 1) && (c % 2 == 1)) begin
            w = {p, img[r][c-1], img[r-1][c], img[r-1][c-1]};
            exp_q.push_back(w);
            pend = 1;
            pend_win = w;
        end
        pos++;
        if (pos == cur_w() * cur_h()) begin
            pos = 0;
            fd_exp = 1;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_valid", o_valid, 0);
            chk("rst_window", o_window, 0);
            chk("rst_done", o_frame_done, 0);
            exp_q.delete();
            pos = 0;
            fd_exp = 0;
            pend = 0;
            hold_prev = 0;
        end else begin
            chk("frame_done", o_frame_done, fd_exp);
            if (o_frame_done) fd_cnt++;
            fd_exp = 0;
            chk("ready_rule", o_ready, en & (~o_valid | i_ready));
            if (pend) begin
                chk("win_valid", o_valid, 1);
                chk("win_latency", o_window, pend_win);
                pend = 0;
            end
            if (hold_prev) begin
                chk("hold_valid", o_valid, 1);
                chk("hold_window", o_window, prev_win);
            end
            hold_prev = o_valid && !i_ready;
            prev_win = o_window;
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL spurious_window: got %h expected no window", o_window);
                end else begin
                    win_cnt++;
                    chk("window_order", o_window, exp_q.pop_front());
                end
            end
            if (i_valid && o_ready) model_accept(i_pixel);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pixel(input logic [7:0] p);
        bit ok;
        ok = 0;
        i_valid = 1;
        i_pixel = p;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = o_ready;
        end
        if (!ok) chk("accept_timeout", 0, 1);
        tick();
        i_valid = 0;
    endtask

    task automatic idle(input int n);
        i_valid = 0;
        repeat (n) tick();
    endtask

    task automatic do_reset(input bit s);
        rst = 0;
        sel = s;
        i_valid = 0;
        repeat (2) tick();
        rst = 1;
    endtask

    initial begin
        int w0;
        int f0;
        rst = 0; en = 1; i_ready = 1; sel = 0; i_valid = 0; i_pixel = 0;

        for (int i = 0; i < 16; i++) tbl[i] = '{8'(i), 0, 32'h0, 0};
        tbl[5]  = '{8'd5,  1, {8'd5,  8'd4,  8'd1,  8'd0},  0};
        tbl[7]  = '{8'd7,  1, {8'd7,  8'd6,  8'd3,  8'd2},  0};
        tbl[13] = '{8'd13, 1, {8'd13, 8'd12, 8'd9,  8'd8},  0};
        tbl[15] = '{8'd15, 1, {8'd15, 8'd14, 8'd11, 8'd10}, 1};

        repeat (2) tick();
        rst = 1;

        // 4x4 frame, back-to-back, no backpressure
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) begin
                i_valid = 1;
                i_pixel = tbl[i].pix;
            end else begin
                i_valid = 0;
            end
            @(negedge clk);
            if (i < 16) chk("t_ready", o_ready, 1);
            if (i > 0) begin
                chk("t_valid", o_valid, tbl[i-1].v);
                if (tbl[i-1].v) chk("t_window", o_window, tbl[i-1].win);
                chk("t_done", o_frame_done, tbl[i-1].fd);
            end
            tick();
        end
        idle(2);

        // Downstream stall for 3 cycles on the first window
        w0 = win_cnt;
        for (int p = 0; p < 6; p++) send_pixel(8'(p));
        i_ready = 0;
        i_valid = 1;
        i_pixel = 8'd6;
        repeat (3) begin
            @(negedge clk);
            chk("bp_ready", o_ready, 0);
            chk("bp_window", o_window, {8'd5, 8'd4, 8'd1, 8'd0});
            tick();
        end
        i_ready = 1;
        for (int p = 6; p < 16; p++) send_pixel(8'(p));
        idle(3);
        chk("bp_count", win_cnt - w0, 4);

        // Two frames back-to-back
        for (int p = 0; p < 16; p++) send_pixel(8'(p));
        for (int p = 100; p < 116; p++) begin
            send_pixel(8'(p));
            if (p == 105) begin
                @(negedge clk);
                chk("f2_first", o_window, {8'd105, 8'd104, 8'd101, 8'd100});
                tick();
            end
        end
        idle(3);

        // Reset mid-frame, then a clean frame
        for (int p = 0; p < 7; p++) send_pixel(8'(p));
        rst = 0;
        repeat (2) begin
            @(negedge clk);
            chk("mr_valid", o_valid, 0);
            chk("mr_window", o_window, 0);
        end
        tick();
        rst = 1;
        w0 = win_cnt;
        for (int p = 0; p < 16; p++) send_pixel(8'(p));
        idle(3);
        chk("mr_count", win_cnt - w0, 4);

        // Enable dropped for 2 cycles between pixels 4 and 5
        for (int p = 0; p < 5; p++) send_pixel(8'(p));
        en = 0;
        i_valid = 1;
        i_pixel = 8'd5;
        repeat (2) begin
            @(negedge clk);
            chk("en_ready", o_ready, 0);
            chk("en_done", o_frame_done, 0);
            tick();
        end
        en = 1;
        w0 = win_cnt;
        for (int p = 5; p < 16; p++) send_pixel(8'(p));
        idle(3);
        chk("en_count", win_cnt - w0, 4);

        // 5x3 instance: odd width and height
        do_reset(1);
        w0 = win_cnt;
        f0 = fd_cnt;
        for (int p = 0; p < 15; p++) send_pixel(8'(p));
        idle(3);
        chk("w5_windows", win_cnt - w0, 2);
        chk("w5_done", fd_cnt - f0, 1);

        // Randomized traffic on both instances
        for (int s = 0; s < 2; s++) begin
            do_reset(s[0]);
            repeat (400) begin
                en      = ($urandom_range(0, 9) != 0);
                i_valid = ($urandom_range(0, 3) != 0);
                i_ready = ($urandom_range(0, 3) != 0);
                i_pixel = 8'($urandom);
                tick();
            end
            en = 1;
            i_ready = 1;
            idle(4);
            chk("drain", exp_q.size(), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/pool_window_buffer.md
Name: pool_window_buffer

Overview:
- Streaming 2x2 / stride-2 window former that sits directly upstream of the max-pooling stage.
- Accepts one feature-map pixel per handshake in raster order (row-major, top-left first).
- Buffers one even row in a line buffer.
- Emits each non-overlapping 2x2 window as one registered bundle that the pooling stage consumes.
- Valid/ready on both sides; backpressure from the pooling stage propagates upstream.

Parameters:
- WIDTH, 8, pixel data width in bits.
- IMG_W, 28, feature-map width in pixels (>=2).
- IMG_H, 28, feature-map height in pixels (>=2).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  stage enable; low freezes all state and forces o_ready low.
- i_pixel  input  WIDTH  incoming pixel.
- i_valid  input  1  i_pixel valid.
- o_ready  output  1  stage can accept i_pixel this cycle.
- o_window  output  4*WIDTH  window; [WIDTH-1:0]=top-left, [2W-1:W]=top-right, [3W-1:2W]=bottom-left, [4W-1:3W]=bottom-right.
- o_valid  output  1  o_window valid.
- i_ready  input  1  downstream pooling stage accepts o_window.
- o_frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset (rst low, async):
  - col=0, row=0, o_valid=0, o_window=0, o_frame_done=0, held-pixel register=0.
  - Line buffer contents are not reset.
  - Reset mid-frame discards the partial frame; the next accepted pixel is treated as row 0, col 0.
- Handshakes:
  - o_ready = en & (~o_valid | i_ready), combinational.
  - A pixel is accepted iff i_valid & o_ready.
  - A window is consumed iff o_valid & i_ready.
- Counters (advance only on accept):
  - col counts 0..IMG_W-1, then wraps to 0 and increments row.
  - row counts 0..IMG_H-1, then wraps to 0 (next frame).
- Data path on accept:
  - Even row: line_buf[col] <= i_pixel.
  - Odd row, even col: hold <= i_pixel.
  - Odd row, odd col: o_window <= {i_pixel, hold, line_buf[col], line_buf[col-1]} (bottom-right, bottom-left, top-right, top-left) and o_valid <= 1.
- Latency: o_window/o_valid update on the clock edge that accepts the bottom-right pixel, i.e. visible 1 cycle after acceptance.
- Output hold: while o_valid & ~i_ready, o_window and o_valid stay stable and no pixel is accepted.
- Simultaneous consume and new window in the same cycle: load the new window; o_valid stays 1. Consume with no new window: o_valid <= 0.
- Odd IMG_W: last column of each row is stored/skipped and never windowed; floor(IMG_W/2) windows per row pair.
- Odd IMG_H: last row is accepted but never windowed; floor(IMG_H/2) window rows.
- o_frame_done: 1 for exactly one cycle after accepting pixel (IMG_H-1, IMG_W-1), else 0. This is independent of whether that pixel completed a window.
- en low: counters, line buffer, hold, o_window, o_valid frozen; o_frame_done forced 0. The output handshake is still honoured: if o_valid & i_ready while en=0, o_valid clears.
- Throughput: at most one window per two pixels; no input stall unless downstream withholds i_ready.
- Line buffer: IMG_W x WIDTH, single write and two read addresses (col-1, col); inferable as distributed RAM or registers.

Test Plan:
- IMG_W=4, IMG_H=4, en=1, i_ready=1, pixels 0..15 back-to-back:
  - Windows (TL,TR,BL,BR) = (0,1,4,5), (2,3,6,7), (8,9,12,13), (10,11,14,15).
  - Each window appears the cycle after pixels 5, 7, 13, 15 respectively.
  - o_frame_done pulses once after pixel 15.
  - o_ready never drops.
- Same frame, i_ready=0 for 3 cycles when the first window appears:
  - o_window holds (0,1,4,5) and o_ready=0 for those 3 cycles.
  - Pixel 6 accepted only after i_ready returns.
  - All 4 windows are emitted exactly once, in order.
- IMG_W=5, IMG_H=3, pixels 0..14:
  - Only windows (0,1,5,6) and (2,3,7,8) are emitted.
  - Column 4 and row 2 never appear in a window.
  - o_frame_done pulses after pixel 14.
- Two frames back-to-back, IMG_W=4, IMG_H=4, second frame pixels 100..115:
  - Second frame first window is (100,101,104,105).
  - No stale first-frame data leaks into it.
- Reset mid-frame: assert rst low after pixel 6 of frame 1, then release and send 0..15:
  - o_valid=0 and o_window=0 during reset.
  - Output windows match the first scenario exactly.
- en toggled low for 2 cycles between pixels 4 and 5:
  - o_ready=0 and counters frozen while en is low.
  - Output windows are identical to the first scenario.
